// File: rtl/identificador_param.sv
`default_nettype none
// ============================================================================
// Module   : identificador_param
// Brief    : Groups strobed note codes into words and classifies each word
//            from the prefix of its first note. It also flags aborted words
//            and counts the words that complete.
// Revision : 1.0 - initial release
// ============================================================================
module identificador_param #(
    parameter int         NOTE_W  = 4,
    parameter logic [7:0] MAP     = 8'b10_01_01_00,
    parameter logic [15:0] LENS   = 16'h0443,
    parameter int         TIMEOUT = 64,
    parameter bit         SYNC    = 1'b1,
    parameter int         CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ok,
    input  logic [NOTE_W-1:0] nota,
    output logic              fim,
    output logic [1:0]        tipo,
    output logic              erro,
    output logic [3:0]        estado_atual,
    output logic [3:0]        contagem,
    output logic [CNT_W-1:0]  palavras
);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        PREFIXO = 4'd1,
        CORPO   = 4'd2,
        FIM     = 4'd3,
        ERRO    = 4'd4
    } state_t;

    localparam int              TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic              w_ok_s;
    logic [NOTE_W-1:0] w_nota_s;

    generate
        if (SYNC) begin : g_sync
            logic              ok_meta_q, ok_sync_q;
            logic [NOTE_W-1:0] nota_meta_q, nota_sync_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    ok_meta_q   <= 1'b0;
                    ok_sync_q   <= 1'b0;
                    nota_meta_q <= '0;
                    nota_sync_q <= '0;
                end else begin
                    ok_meta_q   <= ok;
                    ok_sync_q   <= ok_meta_q;
                    nota_meta_q <= nota;
                    nota_sync_q <= nota_meta_q;
                end
            end

            assign w_ok_s   = ok_sync_q;
            assign w_nota_s = nota_sync_q;
        end else begin : g_direct
            assign w_ok_s   = ok;
            assign w_nota_s = nota;
        end
    endgenerate

    state_t            state_q, state_d;
    logic [1:0]        word_t_q, word_t_d;
    logic [1:0]        pref_q, pref_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pend_valid_q, pend_valid_d;
    logic [1:0]        pend_pref_q, pend_pref_d;
    logic              ok_prev_q;
    logic              fim_q, fim_d;
    logic              erro_q, erro_d;
    logic [1:0]        tipo_q, tipo_d;
    logic [CNT_W-1:0]  palavras_q, palavras_d;

    logic       w_accept;
    logic       w_in_valid;
    logic [1:0] w_note_pref;
    logic [1:0] w_in_pref;
    logic [1:0] w_in_type;
    logic [3:0] w_in_len;
    logic [3:0] w_cur_len;
    logic [3:0] w_cnt_inc;
    logic       w_timeout_hit;
    logic       w_nota_low_unused;

    assign w_accept          = w_ok_s & ~ok_prev_q;
    assign w_note_pref       = w_nota_s[NOTE_W-1 -: 2];
    // Only the prefix steers classification; the remaining note bits are don't-care.
    assign w_nota_low_unused = ^w_nota_s[NOTE_W-3:0];
    // A note parked during FIM/ERRO takes the place of a fresh accept in OCIOSO.
    assign w_in_valid        = w_accept | pend_valid_q;
    assign w_in_pref         = pend_valid_q ? pend_pref_q : w_note_pref;
    assign w_in_type         = MAP[{w_in_pref, 1'b0} +: 2];
    assign w_in_len          = LENS[{w_in_type, 2'b00} +: 4];
    assign w_cur_len         = LENS[{word_t_q, 2'b00} +: 4];
    assign w_cnt_inc         = cnt_q + 4'd1;
    assign w_timeout_hit     = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    always_comb begin
        state_d      = state_q;
        word_t_d     = word_t_q;
        pref_d       = pref_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        pend_valid_d = pend_valid_q;
        pend_pref_d  = pend_pref_q;
        tipo_d       = tipo_q;
        palavras_d   = palavras_q;

        case (state_q)
            OCIOSO: begin
                pend_valid_d = 1'b0;
                if (w_in_valid) begin
                    if (w_in_len < 4'd2) begin
                        state_d = ERRO;
                    end else begin
                        word_t_d = w_in_type;
                        pref_d   = w_in_pref;
                        cnt_d    = 4'd1;
                        timer_d  = '0;
                        state_d  = PREFIXO;
                    end
                end
            end
            PREFIXO: begin
                if (w_accept) begin
                    timer_d = '0;
                    if (w_note_pref != pref_q) begin
                        cnt_d   = '0;
                        state_d = ERRO;
                    end else begin
                        cnt_d   = 4'd2;
                        state_d = (w_cur_len == 4'd2) ? FIM : CORPO;
                    end
                end else if (w_timeout_hit) begin
                    cnt_d   = '0;
                    state_d = ERRO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CORPO: begin
                if (w_accept) begin
                    timer_d = '0;
                    cnt_d   = w_cnt_inc;
                    if (w_cnt_inc == w_cur_len) begin
                        state_d = FIM;
                    end
                end else if (w_timeout_hit) begin
                    cnt_d   = '0;
                    state_d = ERRO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FIM, ERRO: begin
                cnt_d   = '0;
                state_d = OCIOSO;
                if (w_accept) begin
                    pend_valid_d = 1'b1;
                    pend_pref_d  = w_note_pref;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = OCIOSO;
            end
        endcase

        if (state_d == FIM) begin
            tipo_d     = word_t_q;
            palavras_d = palavras_q + 1'b1;
        end

        fim_d  = (state_d == FIM);
        erro_d = (state_d == ERRO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= OCIOSO;
            word_t_q     <= '0;
            pref_q       <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_pref_q  <= '0;
            ok_prev_q    <= 1'b0;
            fim_q        <= 1'b0;
            erro_q       <= 1'b0;
            tipo_q       <= '0;
            palavras_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_t_q     <= word_t_d;
            pref_q       <= pref_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            pend_valid_q <= pend_valid_d;
            pend_pref_q  <= pend_pref_d;
            ok_prev_q    <= w_ok_s;
            fim_q        <= fim_d;
            erro_q       <= erro_d;
            tipo_q       <= tipo_d;
            palavras_q   <= palavras_d;
        end
    end

    assign fim          = fim_q;
    assign erro         = erro_q;
    assign tipo         = tipo_q;
    assign estado_atual = state_q;
    assign contagem     = cnt_q;
    assign palavras     = palavras_q;

endmodule
`default_nettype wire
